// File: rtl/run_control.sv
// run_control: CPU-side sequencer driven by the board support block.
//
// Turns boot/halt/continue/step/interrupt requests into sequenced control
// for the CADR core: a stretched cpu_reset, PROM mapping, run/halt state,
// single-step pulses and a latched interrupt with acknowledge. This block is
// the only source of cpu_reset and run for the core.
//
// Parameters:
//   BOOT_HOLD  cycles cpu_reset is held in BOOT after an accepted boot edge (1..255)
//   HB_BITS    heartbeat counter width (used only with RUN_HEARTBEAT_EN)
//
// Optional feature macro: RUN_HEARTBEAT_EN
//   defined   : led blinks with a heartbeat counter MSB in RUN, is steady 1 in
//               HALTED and 0 otherwise.
//   undefined : no counter is built and led = run.
//
// Ports:
//   clk           in   system clock, all logic on posedge
//   reset         in   asynchronous active-high reset
//   boot          in   boot request level (rising edge acted on)
//   halt          in   halt request level
//   cont          in   continue request (rising edge acted on)
//   step          in   single-step request (rising edge acted on)
//   interrupt     in   interrupt request (rising edge acted on)
//   irq_ack       in   core acknowledges irq (level)
//   prom_disable  in   core asks to unmap the PROM (level)
//   cpu_reset     out  reset to the core
//   prom_enable   out  PROM mapped at the boot address
//   run           out  core clock-enable / run
//   cpu_step      out  one-cycle step pulse while halted
//   irq           out  latched interrupt to the core
//   halted        out  core stopped by halt
//   booted        out  set once the first boot completes, cleared only by reset
//   state         out  current FSM state (debug)
//   led           out  status LED
//
// Handshake note: all request inputs are levels sampled on clk; boot, cont,
// step and interrupt act on their rising edge only, so a level held high
// produces exactly one request. irq stays high until irq_ack is seen, and a
// new interrupt edge in the same cycle as irq_ack keeps irq set.

module run_control #(
    parameter int BOOT_HOLD = 16,
    parameter int HB_BITS   = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       boot,
    input  logic       halt,
    input  logic       cont,
    input  logic       step,
    input  logic       interrupt,
    input  logic       irq_ack,
    input  logic       prom_disable,
    output logic       cpu_reset,
    output logic       prom_enable,
    output logic       run,
    output logic       cpu_step,
    output logic       irq,
    output logic       halted,
    output logic       booted,
    output logic [2:0] state,
    output logic       led
);

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_BOOT   = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

    localparam logic [7:0] HOLD_LAST = 8'(BOOT_HOLD - 1);

    logic       rst_hold_q;
    logic [2:0] state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       prom_q, prom_d;
    logic       step_pulse_q, step_pulse_d;
    logic       irq_q, irq_d;
    logic       booted_q, booted_d;
    logic       boot_q, cont_q, step_q, int_q;
    logic       boot_edge, cont_edge, step_edge, int_edge;
    logic       boot_entry;
    logic       active;

    // Reset-release synchronizer. rst_hold_q is the first stage; the
    // RESET->IDLE transition of state_q acts as the second stage, so the FSM
    // leaves RESET on the 2nd clock edge after reset falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_hold_q <= 1'b1;
        end else begin
            rst_hold_q <= 1'b0;
        end
    end

    // Registered copies for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            boot_q <= 1'b0;
            cont_q <= 1'b0;
            step_q <= 1'b0;
            int_q  <= 1'b0;
        end else begin
            boot_q <= boot;
            cont_q <= cont;
            step_q <= step;
            int_q  <= interrupt;
        end
    end

    assign boot_edge = boot & ~boot_q;
    assign cont_edge = cont & ~cont_q;
    assign step_edge = step & ~step_q;
    assign int_edge  = interrupt & ~int_q;

    assign active = (state_q == ST_RUN) || (state_q == ST_HALTED);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        prom_d       = prom_q;
        step_pulse_d = 1'b0;
        irq_d        = irq_q;
        booted_d     = booted_q;
        boot_entry   = 1'b0;

        case (state_q)
            ST_RESET: begin
                if (!rst_hold_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (boot_edge) begin
                    boot_entry = 1'b1;
                end
            end
            ST_BOOT: begin
                // Boot edges are ignored here; the hold count is never restarted.
                if (count_q == HOLD_LAST) begin
                    state_d  = ST_RUN;
                    booted_d = 1'b1;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            ST_RUN: begin
                if (boot_edge) begin
                    boot_entry = 1'b1;
                end else if (halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                // A continue that is actually taken beats a coincident step.
                if (boot_edge) begin
                    boot_entry = 1'b1;
                end else if (cont_edge && !halt) begin
                    state_d = ST_RUN;
                end else if (step_edge) begin
                    step_pulse_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (active && prom_disable) begin
            prom_d = 1'b0;
        end

        // Setting wins over a same-cycle acknowledge.
        if (active && int_edge) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end

        // Boot entry overrides everything else decided this cycle.
        if (boot_entry) begin
            state_d      = ST_BOOT;
            count_d      = 8'd0;
            prom_d       = 1'b1;
            irq_d        = 1'b0;
            step_pulse_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RESET;
            count_q      <= 8'd0;
            prom_q       <= 1'b1;
            step_pulse_q <= 1'b0;
            irq_q        <= 1'b0;
            booted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            prom_q       <= prom_d;
            step_pulse_q <= step_pulse_d;
            irq_q        <= irq_d;
            booted_q     <= booted_d;
        end
    end

    // Core controls decode straight from the state register so that an
    // asynchronous reset is visible on them immediately.
    assign cpu_reset   = !active;
    assign run         = (state_q == ST_RUN);
    assign halted      = (state_q == ST_HALTED);
    assign prom_enable = prom_q;
    assign cpu_step    = step_pulse_q;
    assign irq         = irq_q;
    assign booted      = booted_q;
    assign state       = state_q;

`ifdef RUN_HEARTBEAT_EN
    logic [HB_BITS-1:0] hb_q, hb_d;

    always_comb begin
        hb_d = hb_q;
        if (boot_entry) begin
            hb_d = '0;
        end else if (state_q == ST_RUN) begin
            hb_d = hb_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hb_q <= '0;
        end else begin
            hb_q <= hb_d;
        end
    end

    assign led = (state_q == ST_RUN)    ? hb_q[HB_BITS-1] :
                 (state_q == ST_HALTED) ? 1'b1 : 1'b0;
`else
    assign led = run;
`endif

endmodule

// File: tb/tb_run_control.sv
// Directed testbench for run_control. The driver applies stimulus one clock
// at a time and pushes the hand-derived expected output vector into exp_q;
// a separate monitor pops and compares on the falling edge.
// Vector layout: {state[2:0], cpu_reset, prom_enable, run, cpu_step, irq,
//                 halted, booted, led}

module tb_run_control;

    localparam int W = 11;

    logic       clk = 1'b0;
    logic       reset;
    logic       boot, halt, cont, step, interrupt, irq_ack, prom_disable;
    logic       cpu_reset, prom_enable, run, cpu_step, irq, halted, booted, led;
    logic [2:0] state;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

`ifdef RUN_HEARTBEAT_EN
    logic [3:0] hb_exp  = 4'd0;
    logic [2:0] prev_st = 3'd0;
`endif

    run_control #(
        .BOOT_HOLD(16),
        .HB_BITS  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .boot        (boot),
        .halt        (halt),
        .cont        (cont),
        .step        (step),
        .interrupt   (interrupt),
        .irq_ack     (irq_ack),
        .prom_disable(prom_disable),
        .cpu_reset   (cpu_reset),
        .prom_enable (prom_enable),
        .run         (run),
        .cpu_step    (cpu_step),
        .irq         (irq),
        .halted      (halted),
        .booted      (booted),
        .state       (state),
        .led         (led)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic c(input logic [2:0] st, input logic pe, input logic stp,
                     input logic iq, input logic bt, input string nm);
        logic cr, rn, hl, ld;
        cr = (st == 3'd0) || (st == 3'd1) || (st == 3'd2);
        rn = (st == 3'd3);
        hl = (st == 3'd4);
`ifdef RUN_HEARTBEAT_EN
        if (st == 3'd0 || (st == 3'd2 && prev_st != 3'd2)) hb_exp = 4'd0;
        else if (prev_st == 3'd3) hb_exp = hb_exp + 4'd1;
        ld = rn ? hb_exp[3] : hl;
        prev_st = st;
`else
        ld = rn;
`endif
        exp_q.push_back({st, cr, pe, rn, stp, iq, hl, bt, ld});
        name_q.push_back(nm);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [W-1:0] e, a;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {state, cpu_reset, prom_enable, run, cpu_step, irq, halted, booted, led};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b (st,cr,pe,run,stp,irq,hlt,bt,led)", nm, a, e);
            end
        end
    end

    initial begin
        reset = 1'b1;
        boot = 0; halt = 0; cont = 0; step = 0;
        interrupt = 0; irq_ack = 0; prom_disable = 0;

        tick(); c(3'd0, 1, 0, 0, 0, "reset_state");
        reset = 1'b0;
        tick(); c(3'd0, 1, 0, 0, 0, "release_1clk");
        tick(); c(3'd1, 1, 0, 0, 0, "release_idle");
        tick(); c(3'd1, 1, 0, 0, 0, "idle_hold");

        // Boot: held 3 cycles, re-pulsed inside BOOT (ignored).
        boot = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 2) boot = 1'b0;
            if (i == 5) boot = 1'b1;
            if (i == 7) boot = 1'b0;
            c(3'd2, 1, 0, 0, 0, "boot_hold");
        end
        tick(); c(3'd3, 1, 0, 0, 1, "boot_done");

        // Halt / step / continue
        halt = 1'b1;
        tick(); c(3'd4, 1, 0, 0, 1, "halt_enter");
        step = 1'b1;
        tick(); c(3'd4, 1, 1, 0, 1, "step_pulse");
        step = 1'b0;
        tick(); c(3'd4, 1, 0, 0, 1, "step_one_cycle");
        cont = 1'b1;
        tick(); c(3'd4, 1, 0, 0, 1, "cont_blocked");
        cont = 1'b0;
        tick(); c(3'd4, 1, 0, 0, 1, "cont_blocked_hold");
        halt = 1'b0;
        tick(); c(3'd4, 1, 0, 0, 1, "halted_stay");
        cont = 1'b1;
        tick(); c(3'd3, 1, 0, 0, 1, "cont_resume");
        cont = 1'b0;
        halt = 1'b1;
        tick(); c(3'd4, 1, 0, 0, 1, "halt_again");
        halt = 1'b0;
        tick(); c(3'd4, 1, 0, 0, 1, "halted_again_stay");
        cont = 1'b1; step = 1'b1;
        tick(); c(3'd3, 1, 0, 0, 1, "cont_beats_step");
        cont = 1'b0; step = 1'b0;
        tick(); c(3'd3, 1, 0, 0, 1, "no_late_step");

        // PROM unmap
        prom_disable = 1'b1;
        tick(); c(3'd3, 0, 0, 0, 1, "prom_off");
        prom_disable = 1'b0;
        tick(); c(3'd3, 0, 0, 0, 1, "prom_stays_off");

        // Interrupt latch
        interrupt = 1'b1;
        tick(); c(3'd3, 0, 0, 1, 1, "irq_set");
        interrupt = 1'b0;
        tick(); c(3'd3, 0, 0, 1, 1, "irq_hold");
        interrupt = 1'b1; irq_ack = 1'b1;
        tick(); c(3'd3, 0, 0, 1, 1, "irq_set_wins");
        interrupt = 1'b0;
        tick(); c(3'd3, 0, 0, 0, 1, "irq_ack");
        irq_ack = 1'b0;
        tick(); c(3'd3, 0, 0, 0, 1, "irq_cleared");
        interrupt = 1'b1;
        tick(); c(3'd3, 0, 0, 1, 1, "irq_set2");
        interrupt = 1'b0;

        // Reboot from RUN
        boot = 1'b1;
        tick(); c(3'd2, 1, 0, 0, 1, "boot_from_run");
        boot = 1'b0; interrupt = 1'b1;
        tick(); c(3'd2, 1, 0, 0, 1, "irq_dropped_boot");
        interrupt = 1'b0;
        for (int i = 2; i < 7; i++) begin
            tick(); c(3'd2, 1, 0, 0, 1, "boot_count");
        end
        tick();  // count reaches 7

        // Asynchronous reset in the middle of BOOT
        reset = 1'b1;
        c(3'd0, 1, 0, 0, 0, "async_reset");
        tick(); c(3'd0, 1, 0, 0, 0, "reset_hold");
        reset = 1'b0;
        tick(); c(3'd0, 1, 0, 0, 0, "rerelease_1clk");
        tick(); c(3'd1, 1, 0, 0, 0, "rerelease_idle");

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/run_control.md
Name: run_control

Overview:
- CPU-side responder to the board support block's reset/boot/halt/interrupt requests.
- Turns request levels and pulses into sequenced CPU control: a stretched CPU reset, a PROM enable, a run/halt state, single-step pulses, and a latched interrupt request with acknowledge.
- Sits between the support block and the CADR core. It is the only source of cpu_reset and run for the core.

Parameters:
- BOOT_HOLD, 16: cycles cpu_reset is held after an accepted boot edge; legal range 1..255.
- HB_BITS, 24: heartbeat counter width; used only with RUN_HEARTBEAT_EN.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- reset, input, 1: asynchronous active-high reset.
- boot, input, 1: boot request level; the rising edge is acted on.
- halt, input, 1: halt request level.
- cont, input, 1: continue request; the rising edge is acted on.
- step, input, 1: single-step request; the rising edge is acted on.
- interrupt, input, 1: interrupt request; the rising edge is acted on.
- irq_ack, input, 1: core acknowledges irq; level.
- prom_disable, input, 1: core request to unmap the PROM; level.
- cpu_reset, output, 1: reset to the core.
- prom_enable, output, 1: PROM mapped at the boot address.
- run, output, 1: core clock-enable / run.
- cpu_step, output, 1: one-cycle step pulse while halted.
- irq, output, 1: latched interrupt to the core.
- halted, output, 1: core is stopped by halt.
- booted, output, 1: set once the first boot completes; cleared only by reset.
- state, output, 3: current FSM state, for debug.
- led, output, 1: status LED.

Behaviour:
- Reset (async assert):
  - state=RESET(0), cpu_reset=1, prom_enable=1.
  - run=0, cpu_step=0, irq=0, halted=0, booted=0, led=0.
  - Edge-detect registers and the boot counter cleared.
- Reset release:
  - Deassertion passes through a 2-flop synchronizer.
  - The FSM moves RESET->IDLE on the 2nd clk edge after reset falls.
  - In IDLE, cpu_reset=1 and run=0.
- Edge detection:
  - Each of boot/cont/step/interrupt has a registered copy.
  - edge = in & ~in_q.
  - A level held high produces exactly one edge.
- FSM states: RESET=0, IDLE=1, BOOT=2, RUN=3, HALTED=4. Codes 5-7 are illegal and go to IDLE.
- Boot edge, in IDLE/RUN/HALTED, enters BOOT next cycle:
  - count=0, cpu_reset=1, prom_enable=1, run=0, halted=0, irq=0.
  - Boot has priority over halt/cont/step/interrupt in the same cycle.
- A boot edge while already in BOOT is ignored; the count is not restarted.
- BOOT:
  - count increments every cycle.
  - At count==BOOT_HOLD-1, next state is RUN.
  - cpu_reset is therefore high for exactly BOOT_HOLD cycles in BOOT.
- Entering RUN from BOOT: cpu_reset=0, run=1, booted=1.
- RUN:
  - halt=1 -> HALTED next cycle: run=0, halted=1.
  - prom_disable=1 -> prom_enable=0 next cycle.
  - prom_enable is set again only by reset or boot.
- HALTED, cont edge:
  - If halt=0, go to RUN: run=1, halted=0.
  - If halt=1, the cont edge is ignored.
- HALTED, step edge:
  - cpu_step=1 for exactly one cycle; state remains HALTED.
  - If cont and step edges coincide, cont wins and no step pulse is issued.
- cpu_step is 0 in every state other than HALTED.
- prom_disable is ignored outside RUN/HALTED.
- Interrupt:
  - An interrupt edge in RUN or HALTED sets irq.
  - irq_ack=1 clears irq.
  - Set and ack in the same cycle: irq stays 1.
  - Edges in RESET/IDLE/BOOT are dropped.
- led without the macro: led = run.

Optional Feature:
- Macro: RUN_HEARTBEAT_EN.
- Defined:
  - An HB_BITS free-running counter increments only while run=1; it is cleared by reset and on BOOT entry.
  - In RUN, led = counter MSB.
  - In HALTED, led=1 steady.
  - Otherwise led=0.
- Undefined: no counter is built, and led = run.

Test Plan:
- Reset, then release and hold all inputs 0 -> state=1 after 2 clks; cpu_reset=1, prom_enable=1, run=0, booted=0.
- From IDLE, pulse boot for 3 cycles with BOOT_HOLD=16 -> cpu_reset high exactly 16 cycles in BOOT, then state=3, run=1, booted=1, cpu_reset=0; only one boot sequence is run.
- In RUN: raise halt -> next cycle state=4, halted=1, run=0. Then step edge -> one cpu_step pulse. cont edge with halt=1 -> no change. Drop halt, then cont edge -> state=3, run=1. Cont and step in the same cycle -> RUN with no cpu_step.
- In RUN: prom_disable=1 -> prom_enable=0. Interrupt edge -> irq=1. irq_ack coinciding with a new edge -> irq=1; ack alone -> irq=0. Boot edge -> irq=0, prom_enable=1, state=2.
- Assert reset mid-BOOT at count=7 -> all outputs are at their reset values immediately (asynchronously), and booted=0.
- With RUN_HEARTBEAT_EN and HB_BITS=4, in RUN -> led toggles every 8 cycles. In HALTED -> led=1. In IDLE -> led=0.
